// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Instruction buffer between fetch and decode in the dual-issue pipeline.
// Fetch pushes up to two {pc, inst} pairs per cycle. Decode pops up to two
// per cycle: master is the oldest entry and slave is the one after it.
// Outputs are combinational from registered state, so reads have zero latency.
// There is no write-to-read bypass.
//
// Optional build macro: INST_FIFO_PERF_EN adds the starve_cycles counter.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush                     discard all contents (branch taken / exception)
//   write_en1/2, write_pc1/2,
//   write_inst1/2             fetch push port; entry 2 needs write_en1
//   read_en1/2                decode pop port; slave pop needs read_en1
//   master_valid/pc/inst      entry at the read pointer (0 when invalid)
//   slave_valid/pc/inst       entry after the read pointer (0 when invalid)
//   empty, almost_empty, full occupancy flags (full means count >= DEPTH-1)
//   starve_cycles             (INST_FIFO_PERF_EN only) saturating count of
//                             cycles spent empty outside reset and flush
// ---------------------------------------------------------------------------
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_pc1,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_pc2,
  input  logic [31:0] write_inst2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic        master_valid,
  output logic [31:0] master_pc,
  output logic [31:0] master_inst,
  output logic        slave_valid,
  output logic [31:0] slave_pc,
  output logic [31:0] slave_inst,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
`ifdef INST_FIFO_PERF_EN
  ,
  output logic [31:0] starve_cycles
`endif
);

  localparam int CW = AW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_ge1;
  logic          w_ge2;
  logic          w_pop1;
  logic          w_pop2;
  logic          w_push1;
  logic          w_push2;
  logic [CW-1:0] w_pops;
  logic [CW-1:0] w_req;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_pushes;
  logic [AW-1:0] w_wptr1;
  logic [AW-1:0] w_rptr1;
  logic [63:0]   w_master;
  logic [63:0]   w_slave;

  assign w_ge1 = (r_count != '0);
  assign w_ge2 = (r_count >= CW'(2));

  // Pops are judged against the occupancy before this cycle's writes.
  assign w_pop1 = read_en1 & w_ge1;
  assign w_pop2 = read_en1 & read_en2 & w_ge2;
  assign w_pops = CW'(w_pop1) + CW'(w_pop2);

  // Slots freed by this cycle's pops are reusable in the same cycle.
  // Clamping to free space drops entry 2 before entry 1.
  assign w_req    = CW'(write_en1) + CW'(write_en1 & write_en2);
  assign w_free   = CW'(DEPTH) - r_count + w_pops;
  assign w_pushes = (w_req < w_free) ? w_req : w_free;
  assign w_push1  = (w_pushes != '0);
  assign w_push2  = (w_pushes == CW'(2));

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH on its own.
  assign w_wptr1 = r_wptr + AW'(1);
  assign w_rptr1 = r_rptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + AW'(w_pops);
      r_wptr  <= r_wptr + AW'(w_pushes);
      r_count <= r_count - w_pops + w_pushes;
    end
  end

  // Storage has no reset. Stale contents are never visible because the
  // outputs are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_push1) r_mem[r_wptr]  <= {write_pc1, write_inst1};
      if (w_push2) r_mem[w_wptr1] <= {write_pc2, write_inst2};
    end
  end

  assign w_master = r_mem[r_rptr];
  assign w_slave  = r_mem[w_rptr1];

  assign master_valid = w_ge1;
  assign master_pc    = w_ge1 ? w_master[63:32] : '0;
  assign master_inst  = w_ge1 ? w_master[31:0]  : '0;
  assign slave_valid  = w_ge2;
  assign slave_pc     = w_ge2 ? w_slave[63:32]  : '0;
  assign slave_inst   = w_ge2 ? w_slave[31:0]   : '0;

  assign empty        = ~w_ge1;
  assign almost_empty = ~w_ge2;
  assign full         = (r_count >= CW'(DEPTH - 1));

`ifdef INST_FIFO_PERF_EN
  logic [31:0] r_starve;

  // A flush is cleanup, not starvation, so flushed cycles are not counted.
  // The counter is cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (empty && !flush && (r_starve != 32'hFFFF_FFFF)) begin
      r_starve <= r_starve + 32'd1;
    end
  end

  assign starve_cycles = r_starve;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// ---------------------------------------------------------------------------
// tb_inst_fifo
// Directed scenarios followed by a randomized phase. Every cycle, all DUT
// outputs are compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_inst_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        write_en1;
  logic        write_en2;
  logic [31:0] write_pc1;
  logic [31:0] write_inst1;
  logic [31:0] write_pc2;
  logic [31:0] write_inst2;
  logic        read_en1;
  logic        read_en2;
  logic        master_valid;
  logic [31:0] master_pc;
  logic [31:0] master_inst;
  logic        slave_valid;
  logic [31:0] slave_pc;
  logic [31:0] slave_inst;
  logic        empty;
  logic        almost_empty;
  logic        full;
`ifdef INST_FIFO_PERF_EN
  logic [31:0] starve_cycles;
  logic [31:0] perf_exp;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] q[$];
  logic [31:0] next_pc;
  logic        saw_dropped;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .write_en1    (write_en1),
    .write_en2    (write_en2),
    .write_pc1    (write_pc1),
    .write_inst1  (write_inst1),
    .write_pc2    (write_pc2),
    .write_inst2  (write_inst2),
    .read_en1     (read_en1),
    .read_en2     (read_en2),
    .master_valid (master_valid),
    .master_pc    (master_pc),
    .master_inst  (master_inst),
    .slave_valid  (slave_valid),
    .slave_pc     (slave_pc),
    .slave_inst   (slave_inst),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full)
`ifdef INST_FIFO_PERF_EN
    ,
    .starve_cycles(starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] m;
    logic [63:0] s;
    int          n;
    n = q.size();
    m = (n >= 1) ? q[0] : 64'd0;
    s = (n >= 2) ? q[1] : 64'd0;
    chk("master_valid", 32'(master_valid), 32'(n >= 1));
    chk("master_pc",    master_pc,   m[63:32]);
    chk("master_inst",  master_inst, m[31:0]);
    chk("slave_valid",  32'(slave_valid), 32'(n >= 2));
    chk("slave_pc",     slave_pc,    s[63:32]);
    chk("slave_inst",   slave_inst,  s[31:0]);
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_empty", 32'(almost_empty), 32'(n < 2));
    chk("full",         32'(full),         32'(n >= DEPTH - 1));
`ifdef INST_FIFO_PERF_EN
    chk("starve_cycles", starve_cycles, perf_exp);
`endif
  endtask

  // Apply one clock with the currently driven inputs and update the model.
  // Pops are taken first, so the room left for pushes equals DEPTH minus the
  // occupancy after the pops.
  task automatic cycle();
    int req;
    int room;
`ifdef INST_FIFO_PERF_EN
    if (rst) perf_exp = 32'd0;
    else if (!flush && q.size() == 0 && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 32'd1;
`endif
    if (rst || flush) begin
      q.delete();
    end else begin
      if (read_en1 && q.size() >= 1) begin
        if (read_en2 && q.size() >= 2) void'(q.pop_front());
        void'(q.pop_front());
      end
      req  = write_en1 ? (write_en2 ? 2 : 1) : 0;
      room = DEPTH - q.size();
      if (req >= 1 && room >= 1) q.push_back({write_pc1, write_inst1});
      if (req == 2 && room >= 2) q.push_back({write_pc2, write_inst2});
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    write_en1 = 0; write_en2 = 0;
    read_en1 = 0; read_en2 = 0;
  endtask

  task automatic set_push(input int n);
    write_en1   = (n >= 1);
    write_en2   = (n == 2);
    write_pc1   = next_pc;
    write_inst1 = $urandom;
    write_pc2   = next_pc + 32'd4;
    write_inst2 = $urandom;
    next_pc     = next_pc + 32'(4 * n);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    write_pc1 = 0; write_inst1 = 0; write_pc2 = 0; write_inst2 = 0;
    next_pc = 0;
`ifdef INST_FIFO_PERF_EN
    perf_exp = 0;
`endif
    idle();
    #2;

    // Reset state.
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);

    // Test 1: a pair pushed into an empty FIFO appears on the next cycle.
    write_en1 = 1; write_en2 = 1;
    write_pc1 = 32'h1000; write_inst1 = 32'hA;
    write_pc2 = 32'h1004; write_inst2 = 32'hB;
    cycle();
    chk("t1_master_pc",   master_pc,   32'h1000);
    chk("t1_master_inst", master_inst, 32'hA);
    chk("t1_slave_pc",    slave_pc,    32'h1004);
    chk("t1_slave_inst",  slave_inst,  32'hB);
    chk("t1_almost_empty", 32'(almost_empty), 32'd0);
    idle(); read_en1 = 1; read_en2 = 1;
    cycle();

    // Test 2: with 8 entries held, two pops and two pushes in one cycle.
    idle();
    next_pc = 32'h2000;
    for (int i = 0; i < 4; i++) begin set_push(2); cycle(); end
    idle(); set_push(2); read_en1 = 1; read_en2 = 1;
    cycle();
    chk("t2_master_pc", master_pc, 32'h2008);
    idle(); read_en1 = 1; read_en2 = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t2_drained", 32'(empty), 32'd1);

    // Test 3: fill to DEPTH-1, then overflow with a pair.
    do_reset();
    next_pc = 32'h3000;
    for (int i = 0; i < 7; i++) begin set_push(2); cycle(); end
    set_push(1); cycle();
    chk("t3_full_at_15", 32'(full), 32'd1);
    set_push(2); cycle();   // entry 2 (pc 0x3040) must be dropped
    idle(); read_en1 = 1; read_en2 = 1;
    saw_dropped = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if ((master_valid && master_pc == 32'h3040) || (slave_valid && slave_pc == 32'h3040))
        saw_dropped = 1'b1;
    end
    chk("t3_dropped_pc_seen", 32'(saw_dropped), 32'd0);

    // Test 4: a flush discards contents and same-cycle reads and writes.
    do_reset();
    next_pc = 32'h4000;
    for (int i = 0; i < 3; i++) begin set_push(2); cycle(); end
    set_push(1); read_en1 = 1; flush = 1;
    cycle();
    chk("t4_empty",        32'(empty),        32'd1);
    chk("t4_master_valid", 32'(master_valid), 32'd0);
    chk("t4_master_pc",    master_pc,         32'd0);
    idle();

    // Test 5: full-rate streaming across the index wrap.
    do_reset();
    next_pc = 32'h5000;
    set_push(2); cycle();
    for (int i = 0; i < 7; i++) begin
      set_push(2); read_en1 = 1; read_en2 = 1; cycle();
    end
    for (int i = 0; i < 10; i++) begin
      set_push(2); read_en1 = 1; read_en2 = 1; cycle();
    end
    chk("t5_master_pc", master_pc, 32'h5000 + 32'd4 * 32'd34);
    idle(); read_en1 = 1; read_en2 = 1; cycle();

`ifdef INST_FIFO_PERF_EN
    // Test 6: the starvation counter. Four idle cycles plus the push cycle
    // are five empty cycles counted before the entry appears on master.
    do_reset();
    next_pc = 32'h6000;
    for (int i = 0; i < 4; i++) cycle();
    set_push(1); cycle();
    chk("t6_starve_on_master", starve_cycles, 32'd5);
    idle(); cycle(); cycle();
    chk("t6_starve_held", starve_cycles, 32'd5);
    read_en1 = 1; cycle();
    idle(); flush = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_starve_flush", starve_cycles, 32'd5);
    idle();
`endif

    // Randomized phase. Pushes respect the full flag; write_en2 is
    // sometimes raised without write_en1 and must then be ignored.
    do_reset();
    next_pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      int r;
      idle();
      r = $urandom_range(0, 3);
      if (q.size() < DEPTH - 1) begin
        if (r == 3) begin
          set_push(0);
          write_en2 = 1;
        end else begin
          set_push(r);
        end
      end
      read_en1 = ($urandom_range(0, 2) != 0);
      read_en2 = $urandom_range(0, 1) != 0;
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
